// File: rtl/rom_subtractor_serial_pkg.sv
// Shared constants, FSM encoding and ROM addressing for rom_subtractor_serial.
package rom_subtractor_serial_pkg;

    localparam int unsigned SLICE_W   = 2;
    localparam int unsigned ROM_DEPTH = 32;
    localparam int unsigned ROM_AW    = $clog2(ROM_DEPTH);

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } state_e;

    // ROM address layout: {a2, b2, borrow_in}
    function automatic logic [ROM_AW-1:0] rom_addr(input logic [SLICE_W-1:0] a2,
                                                   input logic [SLICE_W-1:0] b2,
                                                   input logic               bin);
        return {a2, b2, bin};
    endfunction

endpackage

// File: rtl/rom_subtractor_serial_sub_rom_2bit.sv
// sub_rom_2bit: 32x3 constant lookup {a2,b2,bin} -> {bout,diff2} for one 2-bit slice.
module sub_rom_2bit
    import rom_subtractor_serial_pkg::*;
(
    input  logic [SLICE_W-1:0] a2,
    input  logic [SLICE_W-1:0] b2,
    input  logic               bin,
    output logic [SLICE_W-1:0] diff2,
    output logic               bout
);

    logic [ROM_AW-1:0] addr;
    logic [2:0]        entry;

    assign addr = rom_addr(a2, b2, bin);

    // Constant table; each entry is {borrow_out, diff2}
    always_comb begin
        entry = 3'b000;
        case (addr)
            5'd0:  entry = 3'b000;
            5'd1:  entry = 3'b111;
            5'd2:  entry = 3'b111;
            5'd3:  entry = 3'b110;
            5'd4:  entry = 3'b110;
            5'd5:  entry = 3'b101;
            5'd6:  entry = 3'b101;
            5'd7:  entry = 3'b100;
            5'd8:  entry = 3'b001;
            5'd9:  entry = 3'b000;
            5'd10: entry = 3'b000;
            5'd11: entry = 3'b111;
            5'd12: entry = 3'b111;
            5'd13: entry = 3'b110;
            5'd14: entry = 3'b110;
            5'd15: entry = 3'b101;
            5'd16: entry = 3'b010;
            5'd17: entry = 3'b001;
            5'd18: entry = 3'b001;
            5'd19: entry = 3'b000;
            5'd20: entry = 3'b000;
            5'd21: entry = 3'b111;
            5'd22: entry = 3'b111;
            5'd23: entry = 3'b110;
            5'd24: entry = 3'b011;
            5'd25: entry = 3'b010;
            5'd26: entry = 3'b010;
            5'd27: entry = 3'b001;
            5'd28: entry = 3'b001;
            5'd29: entry = 3'b000;
            5'd30: entry = 3'b000;
            5'd31: entry = 3'b111;
            default: entry = 3'b000;
        endcase
    end

    assign bout  = entry[2];
    assign diff2 = entry[1:0];

endmodule

// File: rtl/rom_subtractor_serial.sv
// rom_subtractor_serial: WIDTH-bit subtractor, one 2-bit ROM slice per clock, LSB first.
// Optional signed-overflow output Ovf enabled by defining SUB_OVERFLOW_FLAG_EN.
module rom_subtractor_serial
    import rom_subtractor_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   diff_q;
    logic [IDX_W-1:0]   idx_q;
    logic               borrow_q;
    logic               busy_q;
    logic               done_q;
    logic               bout_q;

    logic [IDX_W:0]     slice_lsb;
    logic [SLICE_W-1:0] rom_diff;
    logic               rom_bout;
    logic               last_slice;

    assign slice_lsb  = {idx_q, 1'b0};
    assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

    sub_rom_2bit u_rom (
        .a2    (a_q[slice_lsb +: SLICE_W]),
        .b2    (b_q[slice_lsb +: SLICE_W]),
        .bin   (borrow_q),
        .diff2 (rom_diff),
        .bout  (rom_bout)
    );

`ifdef SUB_OVERFLOW_FLAG_EN
    logic ovf_q;
    logic ovf_d;

    // Signed overflow from operand signs and the final slice's result MSB
    assign ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (rom_diff[SLICE_W-1] != a_q[WIDTH-1]);

    // Overflow flag: cleared on accept, updated with done
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((state_q != ST_RUN) && start) begin
            ovf_q <= 1'b0;
        end else if ((state_q == ST_RUN) && last_slice) begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`endif

    // Control FSM, operand capture and per-slice result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= A;
                        b_q      <= B;
                        borrow_q <= Bin;
                        diff_q   <= '0;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    diff_q[slice_lsb +: SLICE_W] <= rom_diff;
                    borrow_q <= rom_bout;
                    idx_q    <= idx_q + IDX_W'(1);
                    if (last_slice) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bout_q  <= rom_bout;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Diff = diff_q;
    assign Bout = bout_q;

endmodule

// File: tb/tb_rom_subtractor_serial.sv
// Self-checking bench for rom_subtractor_serial (WIDTH=8); honours SUB_OVERFLOW_FLAG_EN.
module tb_rom_subtractor_serial;

    localparam int unsigned W  = 8;
    localparam int unsigned NS = W / 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         busy;
    logic         done;
    logic [W-1:0] Diff;
    logic         Bout;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic         Ovf;
`endif

    int checks = 0;
    int errors = 0;

    rom_subtractor_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .Bout  (Bout)
`ifdef SUB_OVERFLOW_FLAG_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: arithmetic straight from the subtraction definition
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int r;
        r  = int'(a) - int'(b) - int'(bin);
        d  = W'(r);
        bo = (r < 0);
        ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    endtask

    // Present operands with start for one edge, then scramble the inputs
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    endtask

    // Follow an accepted op through its run; returns in the done cycle
    task automatic check_run(input logic [W-1:0] ed, input logic eb, input logic eo,
                             input string name, input bit noise);
        chk({name, "_busy_e0"}, 32'(busy), 32'd1);
        chk({name, "_done_e0"}, 32'(done), 32'd0);
        for (int k = 1; k <= int'(NS); k++) begin
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (k < int'(NS)) begin
                chk($sformatf("%s_busy_e%0d", name, k), 32'(busy), 32'd1);
                chk($sformatf("%s_done_e%0d", name, k), 32'(done), 32'd0);
            end else begin
                chk({name, "_busy_end"}, 32'(busy), 32'd0);
                chk({name, "_done_end"}, 32'(done), 32'd1);
                chk({name, "_diff"}, 32'(Diff), 32'(ed));
                chk({name, "_bout"}, 32'(Bout), 32'(eb));
`ifdef SUB_OVERFLOW_FLAG_EN
                chk({name, "_ovf"}, 32'(Ovf), 32'(eo));
`endif
            end
        end
    endtask

    // One idle cycle after done: pulse gone, results held
    task automatic check_idle(input logic [W-1:0] ed, input logic eb, input string name);
        @(posedge clk); #1;
        chk({name, "_done_off"}, 32'(done), 32'd0);
        chk({name, "_busy_off"}, 32'(busy), 32'd0);
        chk({name, "_diff_hold"}, 32'(Diff), 32'(ed));
        chk({name, "_bout_hold"}, 32'(Bout), 32'(eb));
    endtask

    initial begin
        logic [W-1:0] ra, rb, ed;
        logic         rbin, eb, eo;

        vecs[0] = '{a: 8'h35, b: 8'h12, bin: 1'b0, diff: 8'h23, bout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, diff: 8'hFF, bout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, diff: 8'h7F, bout: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, diff: 8'h00, bout: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, diff: 8'hFF, bout: 1'b1, ovf: 1'b0};
        vecs[5] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, diff: 8'h80, bout: 1'b1, ovf: 1'b1};
        vecs[6] = '{a: 8'hA5, b: 8'h5A, bin: 1'b0, diff: 8'h4B, bout: 1'b0, ovf: 1'b1};

        rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(Diff), 32'd0);
        chk("rst_bout", 32'(Bout), 32'd0);
`ifdef SUB_OVERFLOW_FLAG_EN
        chk("rst_ovf", 32'(Ovf), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            drive_start(vecs[i].a, vecs[i].b, vecs[i].bin);
            check_run(vecs[i].diff, vecs[i].bout, vecs[i].ovf, $sformatf("vec%0d", i), 1'b0);
            check_idle(vecs[i].diff, vecs[i].bout, $sformatf("vec%0d", i));
        end

        // start at edge 2 of a busy op is ignored; timing unchanged
        drive_start(8'h35, 8'h12, 1'b0);
        @(posedge clk); #1;
        A = 8'hC3; B = 8'h99; Bin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_busy_e2", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("ign_busy_e3", 32'(busy), 32'd1);
        chk("ign_done_e3", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("ign_done_e4", 32'(done), 32'd1);
        chk("ign_diff", 32'(Diff), 32'h23);
        chk("ign_bout", 32'(Bout), 32'd0);
        check_idle(8'h23, 1'b0, "ign");

        // Back-to-back: second start accepted in the done cycle
        drive_start(8'h10, 8'h0F, 1'b1);
        check_run(8'h00, 1'b0, 1'b0, "b2b_first", 1'b0);
        drive_start(8'h05, 8'h07, 1'b0);
        chk("b2b_diff_cleared", 32'(Diff), 32'd0);
        check_run(8'hFE, 1'b1, 1'b0, "b2b_second", 1'b0);
        check_idle(8'hFE, 1'b1, "b2b_second");

        // Reset at edge 2 mid-run aborts without a done pulse
        drive_start(8'h35, 8'h12, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_diff", 32'(Diff), 32'd0);
        chk("mrst_bout", 32'(Bout), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("mrst_nodone%0d", k), 32'(done), 32'd0);
        end
        drive_start(8'h80, 8'h01, 1'b0);
        check_run(8'h7F, 1'b0, 1'b1, "post_rst", 1'b0);
        check_idle(8'h7F, 1'b0, "post_rst");

        // Randomized ops, with stray starts while busy and random gaps
        for (int n = 0; n < 60; n++) begin
            ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
            if (n % 10 == 0) rb = ra;
            model(ra, rb, rbin, ed, eb, eo);
            drive_start(ra, rb, rbin);
            check_run(ed, eb, eo, $sformatf("rnd%0d", n), 1'b1);
            if ($urandom_range(0, 2) != 0) begin
                check_idle(ed, eb, $sformatf("rnd%0d", n));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_subtractor_serial.md
Name: rom_subtractor_serial

Overview:
- Multi-cycle N-bit subtractor built from a 2-bit ROM slice: a 32-entry lookup of {a2, b2, borrow_in} -> {borrow_out, diff2}.
- Processes one 2-bit slice per clock, LSB first, under a start/busy/done handshake.
- Inverse-operation companion to the team's ROM-based 2-bit adder; shares its lookup-table arithmetic style.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled on rising edge of clk
- A  input  WIDTH  minuend; captured when start is accepted
- B  input  WIDTH  subtrahend; captured when start is accepted
- Bin  input  1  borrow-in; captured when start is accepted
- busy  output  1  high while slices are being processed
- done  output  1  one-cycle completion pulse
- Diff  output  WIDTH  result, (A - B - Bin) mod 2^WIDTH
- Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned)

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, Diff=0, Bout=0; internal operand, slice index and borrow registers cleared.
- States:
  - IDLE: start=1 -> latch A, B, Bin; clear Diff; index=0; go RUN; busy=1 from the next cycle.
  - RUN: at each edge, ROM-look up slice[index] with the current borrow.
    - Write diff2 into Diff[2*index+1:2*index]; register borrow_out; index++.
    - After slice WIDTH/2-1 is written: go DONE, busy=0, done=1, Bout=final borrow.
  - DONE: lasts one cycle. done=0 on the next edge; go IDLE.
    - start=1 while in DONE is accepted exactly as in IDLE (back-to-back operation).
- Timing: start sampled at edge 0 -> slices written at edges 1..WIDTH/2 -> done high for the cycle after edge WIDTH/2.
  - Latency: WIDTH/2 cycles. Throughput: one result per WIDTH/2+1 cycles.
- Diff and Bout hold their last values after done, until the next accepted start clears Diff.
- start while busy: ignored. In-flight operands are unaffected and there is no queuing.
- A, B and Bin may change freely after acceptance; only the latched copies are used.
- rst asserted mid-RUN: the next edge forces the full reset state; no done pulse for the aborted operation.
- ROM contents must be exactly equal to the arithmetic: diff2 = (a2 - b2 - bin) mod 4; borrow_out = (a2 < b2 + bin).
- No X on any output after the first reset edge.

Optional Feature:
- Macro: SUB_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output port Ovf (1 bit), reset 0, updated together with done.
  - Ovf=1 iff the signed two's-complement result overflows: A[MSB] != B[MSB] and Diff[MSB] != A[MSB].
  - Held like Diff until the next accepted start.
- Undefined: no Ovf port and no associated logic.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, RUN, DONE as 2-bit localparams).
  - SLICE_W = 2.
  - ROM depth constant (32).
- Sub-module sub_rom_2bit: combinational 32x3 lookup.
  - Inputs a2, b2, bin; outputs diff2, bout.
  - Table initialised from constants, not an adder expression.
- Top level holds the FSM, operand registers, slice index counter and result assembly.

Test Plan (WIDTH=8):
- A=0x35, B=0x12, Bin=0, start at edge 0 -> busy high for edges 1..4; done high only in the cycle after edge 4; Diff=0x23, Bout=0.
- A=0x00, B=0x01, Bin=0 -> Diff=0xFF, Bout=1. With SUB_OVERFLOW_FLAG_EN: Ovf=0.
- A=0x80, B=0x01, Bin=0 -> Diff=0x7F, Bout=0. With SUB_OVERFLOW_FLAG_EN: Ovf=1.
- A=0x10, B=0x0F, Bin=1 -> Diff=0x00, Bout=0. Then start again in the DONE cycle with A=0x05, B=0x07, Bin=0 -> Diff=0xFE, Bout=1, 5 cycles later.
- start pulsed at edge 2 of a busy operation with different operands -> ignored; the original result is produced with unchanged done timing.
- rst asserted at edge 2 mid-RUN -> at that edge busy=0, Diff=0, Bout=0; no done pulse. Next start operates normally.
